// File: rtl/tas_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tas_pkg
// Purpose  : Shared types and constants for the temperature acquisition
//            packet controller: FSM state encoding, default header bytes and
//            a constant ceil-log2 helper for sizing counters and shifts.
// Revision : 1.0 - initial release
// ============================================================================
package tas_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    TEMP_RX = 2'd1,
    SKIP_RX = 2'd2,
    WRITE   = 2'd3
  } state_t;

  localparam logic [7:0] HDR_TEMP_C = 8'hA5;
  localparam logic [7:0] HDR_SKIP_C = 8'hC3;

  // Smallest r with (1 << r) >= value; 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tas_byte_accum.sv
`default_nettype none
// ============================================================================
// Module   : tas_byte_accum
// Purpose  : Bit/byte framing counters and data-byte accumulator.
// Ports    : clk_50, reset_n  - clock, async active-low reset
//            clear            - restart framing (bit_cnt takes bit_valid)
//            run              - framing active (packet body in progress)
//            capture          - byte_in holds freshly shifted data (ena_d)
//            acc_en           - captured bytes are added into sum
//            bit_valid        - serial bit strobe
//            byte_in[7:0]     - shift register parallel output
//            sum              - running sum of captured bytes
//            last_byte        - final byte of the packet captured this cycle
// Revision : 1.0 - initial release
// ============================================================================
module tas_byte_accum
  import tas_pkg::*;
#(
  parameter int  NUM_BYTES = 4,
  localparam int CNT_W     = clog2(NUM_BYTES),
  localparam int SUM_W     = 8 + CNT_W
) (
  input  logic             clk_50,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             run,
  input  logic             capture,
  input  logic             acc_en,
  input  logic             bit_valid,
  input  logic [7:0]       byte_in,
  output logic [SUM_W-1:0] sum,
  output logic             last_byte
);

  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic             byte_rdy;   // 8th bit shifted last cycle; byte_in now complete
  logic             cap;

  assign cap       = run & capture & byte_rdy;
  assign last_byte = cap & (byte_cnt == CNT_W'(NUM_BYTES - 1));

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= 3'd0;
      byte_cnt <= '0;
      sum      <= '0;
      byte_rdy <= 1'b0;
    end else if (clear) begin
      // A bit arriving in the header-match cycle is already data bit 0.
      bit_cnt  <= {2'b00, bit_valid};
      byte_cnt <= '0;
      sum      <= '0;
      byte_rdy <= 1'b0;
    end else if (run) begin
      if (bit_valid) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      byte_rdy <= bit_valid & (bit_cnt == 3'd7);
      if (cap) begin
        byte_cnt <= byte_cnt + CNT_W'(1);
        if (acc_en) begin
          sum <= sum + SUM_W'(byte_in);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tas_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tas_pkt_ctrl
// Purpose  : Sequences the serial-to-parallel shift register: hunts for a
//            header byte, frames NUM_BYTES data bytes, averages temperature
//            packets and writes the result to a downstream FIFO.
// Ports    : clk_50, reset_n  - 50 MHz clock, async active-low reset
//            bit_valid        - serial bit strobe
//            shift_ena        - shift register data enable (= bit_valid)
//            byte_in[7:0]     - shift register parallel output
//            fifo_full        - downstream FIFO full
//            avg_out[7:0]     - averaged temperature byte
//            avg_wr           - one-cycle FIFO write strobe
//            overflow         - sticky: an average was dropped (FIFO full)
//            frame_err        - one-cycle pulse on in-packet timeout
// Revision : 1.0 - initial release
// ============================================================================
module tas_pkt_ctrl
  import tas_pkg::*;
#(
  parameter logic [7:0] HDR_TEMP    = HDR_TEMP_C,
  parameter logic [7:0] HDR_SKIP    = HDR_SKIP_C,
  parameter int         NUM_BYTES   = 4,
  parameter int         TIMEOUT_CYC = 1024
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic       bit_valid,
  output logic       shift_ena,
  input  logic [7:0] byte_in,
  input  logic       fifo_full,
  output logic [7:0] avg_out,
  output logic       avg_wr,
  output logic       overflow,
  output logic       frame_err
);

  localparam int CNT_W  = clog2(NUM_BYTES);
  localparam int SUM_W  = 8 + CNT_W;
  localparam int IDLE_W = (clog2(TIMEOUT_CYC) < 1) ? 1 : clog2(TIMEOUT_CYC);

  state_t             state;
  state_t             state_nxt;
  logic               ena_d;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               in_rx;
  logic               timeout;
  logic               hdr_temp;
  logic               hdr_skip;
  logic               acc_clear;
  logic               acc_run;
  logic               acc_sum_en;
  logic               write_go;
  logic               write_drop;
  logic               last_byte;
  logic [SUM_W-1:0]   sum;

  // byte_in is only trusted one cycle after a shift (ena_d), when it
  // already contains the newest bit.
  assign in_rx    = (state == TEMP_RX) || (state == SKIP_RX);
  assign timeout  = in_rx && (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1));
  assign hdr_temp = (state == HUNT) && ena_d && (byte_in == HDR_TEMP);
  assign hdr_skip = (state == HUNT) && ena_d && (byte_in == HDR_SKIP);

  // State register, shift-enable delay and idle timer
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= HUNT;
      ena_d    <= 1'b0;
      idle_cnt <= '0;
    end else begin
      state <= state_nxt;
      ena_d <= shift_ena;
      if (in_rx && !bit_valid && !timeout) begin
        idle_cnt <= idle_cnt + IDLE_W'(1);
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  // Next-state logic; timeout takes precedence over framing progress
  always_comb begin
    state_nxt = state;
    case (state)
      HUNT: begin
        if (hdr_temp) begin
          state_nxt = TEMP_RX;
        end else if (hdr_skip) begin
          state_nxt = SKIP_RX;
        end
      end
      TEMP_RX: begin
        if (timeout) begin
          state_nxt = HUNT;
        end else if (last_byte) begin
          state_nxt = WRITE;
        end
      end
      SKIP_RX: begin
        if (timeout || last_byte) begin
          state_nxt = HUNT;
        end
      end
      WRITE:   state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  // Output / control decode
  always_comb begin
    shift_ena  = bit_valid;
    frame_err  = timeout;
    acc_clear  = hdr_temp | hdr_skip | timeout;
    acc_run    = in_rx;
    acc_sum_en = (state == TEMP_RX);
    write_go   = (state == WRITE) && !fifo_full;
    write_drop = (state == WRITE) && fifo_full;
  end

  // avg_out and avg_wr are registered together so the FIFO sees the data
  // and its strobe in the same cycle.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      avg_out  <= 8'h00;
      avg_wr   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      avg_wr <= write_go;
      if (state == WRITE) begin
        avg_out <= 8'(sum >> CNT_W);
      end
      if (write_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  tas_byte_accum #(
    .NUM_BYTES (NUM_BYTES)
  ) u_byte_accum (
    .clk_50    (clk_50),
    .reset_n   (reset_n),
    .clear     (acc_clear),
    .run       (acc_run),
    .capture   (ena_d),
    .acc_en    (acc_sum_en),
    .bit_valid (bit_valid),
    .byte_in   (byte_in),
    .sum       (sum),
    .last_byte (last_byte)
  );

endmodule
`default_nettype wire

// File: tb/tb_tas_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tas_pkt_ctrl
// Purpose  : Directed self-checking bench for tas_pkt_ctrl, including a
//            behavioural model of the LSB-first shift register it controls.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tas_pkt_ctrl;
  import tas_pkg::*;

  logic       clk_50    = 1'b0;
  logic       reset_n   = 1'b0;
  logic       bit_valid = 1'b0;
  logic       ser       = 1'b0;
  logic       fifo_full = 1'b0;
  logic       shift_ena;
  logic [7:0] byte_in;
  logic [7:0] avg_out;
  logic       avg_wr;
  logic       overflow;
  logic       frame_err;
  logic [7:0] sreg = 8'h00;

  int         checks   = 0;
  int         failures = 0;
  int         wr_cnt   = 0;
  int         fe_cnt   = 0;
  logic [7:0] wr_data  = 8'h00;

  tas_pkt_ctrl dut (
    .clk_50    (clk_50),
    .reset_n   (reset_n),
    .bit_valid (bit_valid),
    .shift_ena (shift_ena),
    .byte_in   (byte_in),
    .fifo_full (fifo_full),
    .avg_out   (avg_out),
    .avg_wr    (avg_wr),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #10 clk_50 = ~clk_50;

  // Shift register: new bit enters bit 7, updates the edge after shift_ena.
  always @(posedge clk_50) begin
    if (shift_ena) sreg <= {ser, sreg[7:1]};
  end
  assign byte_in = sreg;

  // Monitor on the inactive edge: count writes and frame errors.
  always @(negedge clk_50) begin
    if (avg_wr === 1'b1) begin
      wr_cnt++;
      wr_data = avg_out;
    end
    if (frame_err === 1'b1) fe_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    ser       = b;
    bit_valid = 1'b1;
    cyc(1);
    bit_valid = 1'b0;
    if (gap > 1) cyc(gap - 1);
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 0; i < 8; i++) send_bit(v[i], gap);
  endtask

  task automatic flush(input int gap);
    for (int i = 0; i < 8; i++) send_bit(1'b0, gap);
  endtask

  task automatic send_packet(input logic [7:0] hdr, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input int gap);
    flush(gap);
    send_byte(hdr, gap);
    send_byte(b0, gap);
    send_byte(b1, gap);
    send_byte(b2, gap);
    send_byte(b3, gap);
    cyc(6);
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    bit_valid = 1'b0;
    cyc(2);
    checks++; if (avg_out !== 8'h00) begin failures++; $display("FAIL reset_avg_out: got %h expected 00", avg_out); end
    checks++; if (avg_wr !== 1'b0) begin failures++; $display("FAIL reset_avg_wr: got %b expected 0", avg_wr); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    bit_valid = 1'b1;
    #1;
    checks++; if (shift_ena !== 1'b1) begin failures++; $display("FAIL reset_shift_ena_hi: got %b expected 1", shift_ena); end
    bit_valid = 1'b0;
    #1;
    checks++; if (shift_ena !== 1'b0) begin failures++; $display("FAIL reset_shift_ena_lo: got %b expected 0", shift_ena); end
    cyc(1);
    reset_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_temp_packet;
    int w0;
    w0 = wr_cnt;
    send_packet(8'hA5, 8'h10, 8'h20, 8'h30, 8'h41, 4);
    checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL temp_wr_count: got %0d expected 1", wr_cnt - w0); end
    checks++; if (wr_data !== 8'h28) begin failures++; $display("FAIL temp_avg: got %h expected 28", wr_data); end
  endtask

  task automatic test_skip_packet;
    int w0;
    w0 = wr_cnt;
    send_packet(8'hC3, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4);
    checks++; if (wr_cnt - w0 !== 0) begin failures++; $display("FAIL skip_wr_count: got %0d expected 0", wr_cnt - w0); end
    checks++; if (dut.state !== HUNT) begin failures++; $display("FAIL skip_state: got %0d expected %0d", dut.state, HUNT); end
    w0 = wr_cnt;
    send_packet(8'hA5, 8'h04, 8'h04, 8'h04, 8'h04, 4);
    checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL skip_next_wr_count: got %0d expected 1", wr_cnt - w0); end
    checks++; if (wr_data !== 8'h04) begin failures++; $display("FAIL skip_next_avg: got %h expected 04", wr_data); end
  endtask

  task automatic test_sliding_header;
    int w0;
    w0 = wr_cnt;
    flush(4);
    send_bit(1'b1, 4);
    send_bit(1'b1, 4);
    send_bit(1'b0, 4);
    send_byte(8'hA5, 4);
    for (int i = 0; i < 4; i++) send_byte(8'h80, 4);
    cyc(6);
    checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL slide_wr_count: got %0d expected 1", wr_cnt - w0); end
    checks++; if (wr_data !== 8'h80) begin failures++; $display("FAIL slide_avg: got %h expected 80", wr_data); end
  endtask

  task automatic test_fifo_full;
    int w0;
    w0 = wr_cnt;
    fifo_full = 1'b1;
    send_packet(8'hA5, 8'h10, 8'h20, 8'h30, 8'h41, 4);
    checks++; if (wr_cnt - w0 !== 0) begin failures++; $display("FAIL full_wr_count: got %0d expected 0", wr_cnt - w0); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL full_overflow: got %b expected 1", overflow); end
    fifo_full = 1'b0;
    w0 = wr_cnt;
    send_packet(8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 4);
    checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL full_next_wr_count: got %0d expected 1", wr_cnt - w0); end
    checks++; if (wr_data !== 8'h02) begin failures++; $display("FAIL full_next_avg: got %h expected 02", wr_data); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL full_overflow_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_timeout;
    int w0;
    int fe0;
    int first;
    w0    = wr_cnt;
    fe0   = fe_cnt;
    first = 0;
    flush(1);
    send_byte(8'hA5, 1);
    send_byte(8'h00, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1);
    for (int k = 1; k <= 1100; k++) begin
      @(negedge clk_50);
      if (frame_err === 1'b1 && first == 0) first = k;
      @(posedge clk_50);
      #1;
    end
    checks++; if (first !== 1024) begin failures++; $display("FAIL timeout_cycle: got %0d expected 1024", first); end
    checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL timeout_pulses: got %0d expected 1", fe_cnt - fe0); end
    checks++; if (wr_cnt - w0 !== 0) begin failures++; $display("FAIL timeout_wr_count: got %0d expected 0", wr_cnt - w0); end
    checks++; if (dut.state !== HUNT) begin failures++; $display("FAIL timeout_state: got %0d expected %0d", dut.state, HUNT); end
  endtask

  task automatic test_back_to_back;
    int w0;
    w0 = wr_cnt;
    send_packet(8'hA5, 8'h11, 8'h22, 8'h33, 8'h45, 1);
    checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL b2b_wr_count: got %0d expected 1", wr_cnt - w0); end
    checks++; if (wr_data !== 8'h2A) begin failures++; $display("FAIL b2b_avg: got %h expected 2A", wr_data); end
  endtask

  task automatic test_reset_mid_packet;
    int w0;
    flush(4);
    send_byte(8'hA5, 4);
    send_byte(8'h50, 4);
    send_byte(8'h60, 4);
    cyc(2);
    reset_n = 1'b0;
    #1;
    checks++; if (avg_out !== 8'h00) begin failures++; $display("FAIL midrst_avg_out: got %h expected 00", avg_out); end
    checks++; if (avg_wr !== 1'b0) begin failures++; $display("FAIL midrst_avg_wr: got %b expected 0", avg_wr); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL midrst_overflow: got %b expected 0", overflow); end
    checks++; if (dut.state !== HUNT) begin failures++; $display("FAIL midrst_state: got %0d expected %0d", dut.state, HUNT); end
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    w0 = wr_cnt;
    send_packet(8'hA5, 8'h08, 8'h0C, 8'h10, 8'h14, 4);
    checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL midrst_wr_count: got %0d expected 1", wr_cnt - w0); end
    checks++; if (wr_data !== 8'h0E) begin failures++; $display("FAIL midrst_avg: got %h expected 0E", wr_data); end
  endtask

  initial begin
    test_reset;
    test_temp_packet;
    test_skip_packet;
    test_sliding_header;
    test_fifo_full;
    test_timeout;
    test_back_to_back;
    test_reset_mid_packet;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
